// File: rtl/tblink_rpc_invoke_responder.sv
// ---------------------------------------------------------------------------
// tblink_rpc_invoke_responder
//
// HDL-side responder for TbLink RPC method invocation. It accepts one
// invoke-request message as a 32-bit word stream and buffers the parameters.
// It then presents the call to local BFM logic and waits for a completion
// pulse. Finally it returns a two-word response tagged with the original
// call_id. Only one call is in flight at a time.
//
// Request header : [31:24] method_id, [23:16] nparams, [15:0] call_id
// Response word 0: [31:24] status,    [23:16] method_id, [15:0] call_id
// Response word 1: return value (0 whenever status != 0), rsp_last=1
// Status codes   : 0 OK, 1 short msg, 2 long msg, 3 too many params, 4 timeout
//
// Optional feature macro: TBLINK_RPC_RSP_TIMEOUT_EN
//   When defined, a completion watchdog ends S_WAIT after TIMEOUT_CYCLES
//   cycles and returns status 4. When undefined, S_WAIT waits indefinitely.
//
// Ports
//   clock, reset               : rising-edge clock, async active-high reset
//   req_dat/valid/last/ready   : request word stream in
//   inv_valid/ready            : call presentation handshake to BFM logic
//   inv_method/nparams/params  : call contents; param word i at [32i+31:32i]
//   done_valid, done_retval    : single-cycle completion pulse + return value
//   rsp_dat/valid/last/ready   : response word stream out
//   busy                       : high whenever not idle in S_HDR
// ---------------------------------------------------------------------------
module tblink_rpc_invoke_responder #(
  parameter int MAX_PARAMS     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              req_dat,
  input  logic                     req_valid,
  input  logic                     req_last,
  output logic                     req_ready,
  output logic                     inv_valid,
  input  logic                     inv_ready,
  output logic [7:0]               inv_method,
  output logic [7:0]               inv_nparams,
  output logic [MAX_PARAMS*32-1:0] inv_params,
  input  logic                     done_valid,
  input  logic [31:0]              done_retval,
  output logic [31:0]              rsp_dat,
  output logic                     rsp_valid,
  output logic                     rsp_last,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam logic [2:0] S_HDR    = 3'd0;
  localparam logic [2:0] S_PARAM  = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_INVOKE = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RSP0   = 3'd5;
  localparam logic [2:0] S_RSP1   = 3'd6;

  localparam logic [7:0] MAX_P8 = 8'(MAX_PARAMS);

  localparam logic [7:0] ST_OK    = 8'd0;
  localparam logic [7:0] ST_SHORT = 8'd1;
  localparam logic [7:0] ST_LONG  = 8'd2;
  localparam logic [7:0] ST_OVFL  = 8'd3;
`ifdef TBLINK_RPC_RSP_TIMEOUT_EN
  localparam logic [7:0]  ST_TMO  = 8'd4;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
`endif

  logic [2:0]  r_state;
  logic [7:0]  r_method;
  logic [7:0]  r_nparams;
  logic [15:0] r_call_id;
  logic [7:0]  r_idx;
  logic [7:0]  r_status;
  logic [31:0] r_retval;
  logic [31:0] r_params [MAX_PARAMS];
`ifdef TBLINK_RPC_RSP_TIMEOUT_EN
  logic [31:0] r_wait_cnt;
`endif

  logic       w_req_hs;
  logic [7:0] w_hdr_np;

  // Ready is gated by reset so nothing is consumed while reset is held.
  assign req_ready = ~reset & ((r_state == S_HDR) | (r_state == S_PARAM) |
                               (r_state == S_DRAIN));
  assign w_req_hs  = req_valid & req_ready;
  assign w_hdr_np  = req_dat[23:16];

  assign inv_valid   = (r_state == S_INVOKE);
  assign inv_method  = r_method;
  assign inv_nparams = r_nparams;
  assign rsp_valid   = (r_state == S_RSP0) | (r_state == S_RSP1);
  assign rsp_last    = (r_state == S_RSP1);
  assign busy        = (r_state != S_HDR);

  always_comb begin
    inv_params = '0;
    for (int i = 0; i < MAX_PARAMS; i++) begin
      inv_params[32*i +: 32] = r_params[i];
    end
  end

  always_comb begin
    rsp_dat = '0;
    if (r_state == S_RSP0) begin
      rsp_dat = {r_status, r_method, r_call_id};
    end else if (r_state == S_RSP1) begin
      rsp_dat = (r_status == ST_OK) ? r_retval : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_HDR;
      r_method  <= '0;
      r_nparams <= '0;
      r_call_id <= '0;
      r_idx     <= '0;
      r_status  <= '0;
      r_retval  <= '0;
      for (int i = 0; i < MAX_PARAMS; i++) begin
        r_params[i] <= '0;
      end
`ifdef TBLINK_RPC_RSP_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_req_hs) begin
            r_method  <= req_dat[31:24];
            r_nparams <= w_hdr_np;
            r_call_id <= req_dat[15:0];
            r_idx     <= '0;
            r_status  <= ST_OK;
            r_retval  <= '0;
            for (int i = 0; i < MAX_PARAMS; i++) begin
              r_params[i] <= '0;
            end
            if (w_hdr_np > MAX_P8) begin
              r_status <= ST_OVFL;
              r_state  <= req_last ? S_RSP0 : S_DRAIN;
            end else if (w_hdr_np == 8'd0) begin
              if (req_last) begin
                r_state <= S_INVOKE;
              end else begin
                r_status <= ST_LONG;
                r_state  <= S_DRAIN;
              end
            end else begin
              r_state <= S_PARAM;
            end
          end
        end

        S_PARAM: begin
          if (w_req_hs) begin
            // r_idx < r_nparams <= MAX_PARAMS here, so the slot always exists.
            for (int i = 0; i < MAX_PARAMS; i++) begin
              if (r_idx == 8'(i)) begin
                r_params[i] <= req_dat;
              end
            end
            r_idx <= r_idx + 8'd1;
            if (r_idx == r_nparams - 8'd1) begin
              if (req_last) begin
                r_state <= S_INVOKE;
              end else begin
                r_status <= ST_LONG;
                r_state  <= S_DRAIN;
              end
            end else if (req_last) begin
              r_status <= ST_SHORT;
              r_state  <= S_RSP0;
            end
          end
        end

        S_DRAIN: begin
          if (w_req_hs && req_last) begin
            r_state <= S_RSP0;
          end
        end

        S_INVOKE: begin
          if (inv_ready) begin
            r_state <= S_WAIT;
`ifdef TBLINK_RPC_RSP_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end

        S_WAIT: begin
          // A completion in the same cycle as the watchdog limit wins.
          if (done_valid) begin
            r_retval <= done_retval;
            r_state  <= S_RSP0;
          end
`ifdef TBLINK_RPC_RSP_TIMEOUT_EN
          else if (r_wait_cnt == TO_LAST) begin
            r_status <= ST_TMO;
            r_retval <= '0;
            r_state  <= S_RSP0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
`endif
        end

        S_RSP0: begin
          if (rsp_ready) begin
            r_state <= S_RSP1;
          end
        end

        S_RSP1: begin
          if (rsp_ready) begin
            r_state <= S_HDR;
          end
        end

        default: begin
          r_state <= S_HDR;
        end
      endcase
    end
  end

endmodule

// File: doc/tblink_rpc_invoke_responder.md
# tblink_rpc_invoke_responder

Synthesizable HDL-side responder for TbLink RPC method invocation. It receives invoke-request messages from the testbench transport as a 32-bit word stream and buffers the parameters. It then presents the call to local BFM logic, waits for completion, and returns a two-word response carrying the original call_id, so the testbench can match it to the outstanding invoke. Only one call is in flight at a time.

## Interface
- MAX_PARAMS, 4: parameter-buffer depth in 32-bit words; range 1..16.
- TIMEOUT_CYCLES, 1024: completion watchdog limit. Used only when TBLINK_RPC_RSP_TIMEOUT_EN is defined.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- req_dat  in  32  request word.
- req_valid  in  1  request word valid.
- req_last  in  1  final word of the request message.
- req_ready  out  1  responder accepts a request word.
- inv_valid  out  1  call presented to BFM logic.
- inv_ready  in  1  BFM logic accepts the call.
- inv_method  out  8  method id.
- inv_nparams  out  8  parameter count.
- inv_params  out  MAX_PARAMS*32  parameters; word i is at bits [32i+31:32i]; unused slots are 0.
- done_valid  in  1  single-cycle completion pulse from BFM logic.
- done_retval  in  32  return value, qualified by done_valid.
- rsp_dat  out  32  response word.
- rsp_valid  out  1  response word valid.
- rsp_last  out  1  final response word.
- rsp_ready  in  1  downstream accepts the response word.
- busy  out  1  high whenever the state is not S_HDR.

## Operation
- Request header word: [31:24] method_id, [23:16] nparams, [15:0] call_id. The header is followed by exactly nparams parameter words. req_last marks the final word of the message.
- States: S_HDR, S_PARAM, S_DRAIN, S_INVOKE, S_WAIT, S_RSP0, S_RSP1.
- S_HDR:
  - On a header handshake: latch method_id, nparams and call_id; clear param slots and the word index; set status to 0.
  - nparams > MAX_PARAMS: status 3. Next state is S_RSP0 if req_last, otherwise S_DRAIN.
  - nparams == 0 with req_last: go to S_INVOKE.
  - nparams == 0 without req_last: status 2, go to S_DRAIN.
  - Otherwise: go to S_PARAM.
- S_PARAM:
  - Each handshake stores the word in slot[index] and increments index.
  - req_last before index reaches nparams-1: status 1, go to S_RSP0.
  - Final expected word with req_last: go to S_INVOKE.
  - Final expected word without req_last: status 2, go to S_DRAIN.
- S_DRAIN: discard words until the req_last handshake, then go to S_RSP0.
- S_INVOKE: inv_valid=1 and holds until inv_ready; the handshake moves to S_WAIT.
- S_WAIT: done_valid captures done_retval and moves to S_RSP0. done_valid in any other state is ignored.
- Response word 0: [31:24] status, [23:16] method_id, [15:0] call_id.
- Response word 1: retval; forced to 0 when status != 0. rsp_last=1 on word 1 only.
- Each response word holds until rsp_ready. The word-1 handshake returns the block to S_HDR.
- Status codes: 0 OK, 1 short message, 2 long message, 3 too many params, 4 timeout.

## Timing
- Reset values: req_ready=0 while reset is asserted. inv_valid, rsp_valid, rsp_last and busy are 0. All data outputs are 0. State is S_HDR.
- req_ready=1 in S_HDR, S_PARAM and S_DRAIN only. It deasserts combinationally in all other states. Every valid&ready cycle consumes one word.
- Last request word accepted at cycle N: inv_valid=1 at N+1. Error paths instead give rsp_valid=1 at N+1.
- done_valid at cycle M: rsp_valid=1 with word 0 at M+1. Word 1 appears the cycle after the word-0 handshake at the earliest.
- With rsp_ready held high, the response takes 2 cycles and the next header is accepted 3 cycles after done_valid.
- inv_* outputs are stable from S_INVOKE entry through S_WAIT.
- Async reset mid-message or mid-response abandons all state immediately with no partial response. The bench must flush the transport after reset.

## Configuration
- TBLINK_RPC_RSP_TIMEOUT_EN defined:
  - A 32-bit counter clears on S_WAIT entry and increments each cycle in S_WAIT.
  - When the counter equals TIMEOUT_CYCLES-1 without done_valid, the block goes to S_RSP0 with status 4 and retval 0.
  - If done_valid arrives in that same cycle, done_valid wins.
  - A later done_valid is ignored.
- Not defined: no counter; S_WAIT waits indefinitely; status 4 is never produced.

## Test plan
- Good call: header 0x0702_1234, params 0xAAAA0001 and 0xBBBB0002 (last); done_retval 0xCAFE at 5 cycles after the inv handshake. Expect inv_params slots 0/1 = those values, slots 2/3 = 0, and response 0x0007_1234 then 0x0000_CAFE with rsp_last.
- Zero-param call: header 0x0300_0001 with req_last. Expect inv_valid the next cycle, inv_nparams=0, and response word 0 = 0x0003_0001.
- Short message: header nparams=3, second param carries req_last. Expect no inv_valid, response 0x01xx_cid then 0x0000_0000.
- Overflow: nparams=5 with MAX_PARAMS=4, 5 params then last. Expect all words drained and status 3.
- Backpressure: rsp_ready low for 4 cycles during both words. Expect rsp_dat stable and no new header accepted until the word-1 handshake.
- Timeout (macro on, TIMEOUT_CYCLES=16): no done_valid. Expect rsp_valid 16 cycles after S_WAIT entry with status 4; a done_valid issued later is ignored. Also assert reset mid-param and expect busy=0 immediately.
